// File: rtl/dds_phase_accum.sv
// Phase accumulator for the DDS chain: adds the active tuning word each enabled cycle,
// with immediate or wrap-deferred (glitch-free) tuning word updates and a phase offset.
module dds_phase_accum #(
    parameter int unsigned N = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         phase_clr,
    input  logic [N-1:0] ftw_in,
    input  logic         ftw_ld,
    input  logic         ftw_sync,
    input  logic [N-1:0] phase_ofs,
    output logic [N-1:0] phase,
    output logic         wrap,
    output logic         ftw_pending,
    output logic [N-1:0] ftw_active
);

    localparam int unsigned SUM_W = N + 1;

    logic [N-1:0]     acc_q,     acc_d;
    logic [N-1:0]     shadow_q,  shadow_d;
    logic [N-1:0]     active_q,  active_d;
    logic             pending_q, pending_d;
    logic [N-1:0]     phase_q,   phase_d;
    logic             wrap_q,    wrap_d;

    logic [SUM_W-1:0] sum_c;
    logic             adv_c;
    logic             carry_c;

    assign sum_c   = SUM_W'(acc_q) + SUM_W'(active_q);
    assign adv_c   = en && !phase_clr;
    assign carry_c = sum_c[N];

    // Next-state: accumulator, output phase and tuning word bookkeeping
    always_comb begin
        acc_d     = acc_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        wrap_d    = 1'b0;
        phase_d   = N'(acc_q + phase_ofs);

        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d  = sum_c[N-1:0];
            wrap_d = carry_c;
        end

        // Deferred word takes effect on a wrap; a coincident deferred load refills the shadow
        if (adv_c && carry_c && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (ftw_ld) begin
            if (ftw_sync) begin
                shadow_d  = ftw_in;
                pending_d = 1'b1;
            end else begin
                active_d  = ftw_in;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            phase_q   <= '0;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
        end
    end

    assign phase       = phase_q;
    assign wrap        = wrap_q;
    assign ftw_pending = pending_q;
    assign ftw_active  = active_q;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Directed bench for dds_phase_accum; expected values are hand-derived per vector.
module tb_dds_phase_accum;

    localparam int unsigned N = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         phase_clr = 1'b0;
    logic [N-1:0] ftw_in = '0;
    logic         ftw_ld = 1'b0;
    logic         ftw_sync = 1'b0;
    logic [N-1:0] phase_ofs = '0;
    logic [N-1:0] phase;
    logic         wrap;
    logic         ftw_pending;
    logic [N-1:0] ftw_active;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dds_phase_accum #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .phase_clr   (phase_clr),
        .ftw_in      (ftw_in),
        .ftw_ld      (ftw_ld),
        .ftw_sync    (ftw_sync),
        .phase_ofs   (phase_ofs),
        .phase       (phase),
        .wrap        (wrap),
        .ftw_pending (ftw_pending),
        .ftw_active  (ftw_active)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; phase_clr = 1'b0; ftw_ld = 1'b0; ftw_sync = 1'b0;
        phase_ofs = '0; ftw_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_imm(input logic [N-1:0] w);
        ftw_in = w; ftw_ld = 1'b1; ftw_sync = 1'b0;
        tick();
        ftw_ld = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] ph, input logic wr,
                              input logic pend, input logic [N-1:0] act);
        check_eq({tag, ".phase"},   32'(phase),       32'(ph));
        check_eq({tag, ".wrap"},    32'(wrap),        32'(wr));
        check_eq({tag, ".pending"}, 32'(ftw_pending), 32'(pend));
        check_eq({tag, ".active"},  32'(ftw_active),  32'(act));
    endtask

    initial begin
        logic [N-1:0] e_ph;
        logic         saw_wrap;

        // 1: step 0x0400, wrap every 16 adds
        tick();
        do_reset();
        check_outs("rst", 14'h0000, 1'b0, 1'b0, 14'h0000);
        en = 1'b1;
        load_imm(14'h0400);
        for (int j = 1; j <= 33; j++) begin
            tick();
            e_ph = N'((j - 1) * 32'h400);
            check_eq($sformatf("t1.phase[%0d]", j), 32'(phase), 32'(e_ph));
            check_eq($sformatf("t1.wrap[%0d]", j), 32'(wrap), 32'((j % 16) == 0));
        end

        // 2: FTW 0x3FFF counts down, carrying on every add but the first
        do_reset();
        en = 1'b1;
        load_imm(14'h3FFF);
        for (int j = 1; j <= 6; j++) begin
            tick();
            e_ph = 14'h0000 - 14'(j - 1);
            check_eq($sformatf("t2.phase[%0d]", j), 32'(phase), 32'(e_ph));
            check_eq($sformatf("t2.wrap[%0d]", j), 32'(wrap), 32'(j >= 2));
        end

        // 3: deferred 0x0800 applied at the next wrap
        do_reset();
        en = 1'b1;
        load_imm(14'h1000);
        tick();
        ftw_in = 14'h0800; ftw_ld = 1'b1; ftw_sync = 1'b1;
        tick();
        ftw_ld = 1'b0; ftw_sync = 1'b0;
        check_outs("t3.ld", 14'h1000, 1'b0, 1'b1, 14'h1000);
        tick();
        check_outs("t3.a", 14'h2000, 1'b0, 1'b1, 14'h1000);
        tick();
        check_outs("t3.wrap", 14'h3000, 1'b1, 1'b0, 14'h0800);
        tick();
        check_outs("t3.b", 14'h0000, 1'b0, 1'b0, 14'h0800);
        tick();
        check_outs("t3.c", 14'h0800, 1'b0, 1'b0, 14'h0800);

        // 4: last deferred load wins; coincident load stays pending
        do_reset();
        en = 1'b1;
        load_imm(14'h1000);
        ftw_ld = 1'b1; ftw_sync = 1'b1; ftw_in = 14'h0100;
        tick();
        ftw_in = 14'h0200;
        tick();
        ftw_ld = 1'b0;
        check_outs("t4.two", 14'h1000, 1'b0, 1'b1, 14'h1000);
        tick();
        ftw_ld = 1'b1; ftw_in = 14'h0300;
        tick();
        ftw_ld = 1'b0; ftw_sync = 1'b0;
        check_outs("t4.coinc", 14'h3000, 1'b1, 1'b1, 14'h0200);
        for (int j = 1; j <= 31; j++) tick();
        check_outs("t4.pre", 14'h3C00, 1'b0, 1'b1, 14'h0200);
        tick();
        check_outs("t4.apply", 14'h3E00, 1'b1, 1'b0, 14'h0300);

        // 5: offset and mid-run clear
        do_reset();
        en = 1'b1;
        load_imm(14'h1000);
        tick(); tick(); tick();
        phase_ofs = 14'h2000;
        tick();
        phase_ofs = 14'h0000;
        check_eq("t5.ofs_phase", 32'(phase), 32'h1000);
        check_eq("t5.ofs_wrap", 32'(wrap), 32'h1);
        tick(); tick(); tick();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check_outs("t5.clr", 14'h3000, 1'b0, 1'b0, 14'h1000);
        tick();
        check_eq("t5.after_clr", 32'(phase), 32'h0000);
        tick();
        check_eq("t5.after_clr2", 32'(phase), 32'h1000);

        // 6: reset while pending and enabled, then FTW=0 never wraps
        do_reset();
        en = 1'b1;
        load_imm(14'h1000);
        ftw_ld = 1'b1; ftw_sync = 1'b1; ftw_in = 14'h0100;
        tick();
        ftw_ld = 1'b0; ftw_sync = 1'b0;
        tick();
        check_outs("t6.pre", 14'h1000, 1'b0, 1'b1, 14'h1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("t6.rst", 14'h0000, 1'b0, 1'b0, 14'h0000);
        saw_wrap = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            saw_wrap = saw_wrap | wrap;
        end
        check_eq("t6.no_wrap", 32'(saw_wrap), 32'h0);
        check_eq("t6.phase0", 32'(phase), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
